// File: rtl/bandai2003_pkg.sv
// ============================================================================
// Package  : bandai2003_pkg
// Purpose  : Constants and state encoding shared by the BANDAI2003 mapper
//            and its console-side unlock host.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bandai2003_pkg;

  localparam logic [7:0]  UNLOCK_ACK = 8'h5A;
  localparam logic [7:0]  UNLOCK_NAK = 8'hA5;
  localparam logic [7:0]  ADDR_IDLE  = 8'hFF;
  localparam logic [15:0] FRAME_WORD = 16'h28A0;
  localparam int          FRAME_BITS = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_NAK   = 3'd2,
    ST_HUNT  = 3'd3,
    ST_DATA  = 3'd4,
    ST_TRAIL = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAIL  = 3'd7
  } state_e;

  function automatic logic [7:0] addr_for_state(input state_e s);
    logic [7:0] a;
    a = ADDR_IDLE;
    if (s == ST_ACK) a = UNLOCK_ACK;
    if (s == ST_NAK) a = UNLOCK_NAK;
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bandai2003_unlock_host_if.sv
// ============================================================================
// Interface : bandai2003_unlock_host_if
// Purpose   : Request, cart-bus and status signals of the unlock host.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

interface bandai2003_unlock_host_if;
  logic        start_i;
  logic        si_i;
  logic [7:0]  addr_o;
  logic        addr_oe_o;
  logic        busy_o;
  logic        done_o;
  logic        fail_o;
  logic [15:0] rx_word_o;
  logic        ctrl1_b7_o;

  modport master (
    input  start_i, si_i,
    output addr_o, addr_oe_o, busy_o, done_o, fail_o, rx_word_o, ctrl1_b7_o
  );

  modport slave (
    output start_i, si_i,
    input  addr_o, addr_oe_o, busy_o, done_o, fail_o, rx_word_o, ctrl1_b7_o
  );
endinterface

`default_nettype wire

// File: rtl/bandai2003_sync_bit.sv
// ============================================================================
// Module   : bandai2003_sync_bit
// Purpose  : STAGES-deep single-bit synchronizer; resets to 1 (idle line level).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bandai2003_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= d_i;
      end
    end else begin : g_chain
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/bandai2003_unlock_host.sv
// ============================================================================
// Module   : bandai2003_unlock_host
// Purpose  : Drives the 5Ah/A5h cart unlock, receives and checks the mapper's
//            18-bit reply frame, and sets SYSTEM_CTRL1 bit 7 on a match.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bandai2003_unlock_host
  import bandai2003_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 32,
  parameter logic [15:0] EXPECT      = FRAME_WORD
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  bandai2003_unlock_host_if.master   host_if
);

  localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  // Payload bits only: frame minus start and trailer, counted from zero.
  localparam logic [3:0]     BIT_LAST   = 4'(FRAME_BITS - 3);

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [15:0]    rx_q, rx_d;
  logic           ctrl_q, ctrl_d;
  logic           si_s;

  bandai2003_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (host_if.si_i),
    .q_o   (si_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      rx_q     <= '0;
      ctrl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      ctrl_q   <= ctrl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    ctrl_d   = ctrl_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (host_if.start_i) begin
          state_d  = ST_ACK;
          timer_d  = '0;
          bitcnt_d = '0;
        end
      end
      ST_ACK: state_d = ST_NAK;
      ST_NAK: state_d = ST_HUNT;
      ST_HUNT: begin
        if (!si_s)                     state_d = ST_DATA;
        else if (timer_q == TIMER_LAST) state_d = ST_FAIL;
        else                           timer_d = timer_q + TW'(1);
      end
      ST_DATA: begin
        rx_d = {si_s, rx_q[15:1]};
        if (bitcnt_q == BIT_LAST) state_d  = ST_TRAIL;
        else                      bitcnt_d = bitcnt_q + 4'd1;
      end
      ST_TRAIL: begin
        if (!si_s && (rx_q == EXPECT)) begin
          state_d = ST_DONE;
          ctrl_d  = 1'b1;
        end else begin
          state_d = ST_FAIL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign host_if.addr_o     = addr_for_state(state_q);
  assign host_if.addr_oe_o  = (state_q == ST_ACK) || (state_q == ST_NAK);
  assign host_if.busy_o     = !((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_FAIL));
  assign host_if.done_o     = (state_q == ST_DONE);
  assign host_if.fail_o     = (state_q == ST_FAIL);
  assign host_if.rx_word_o  = rx_q;
  assign host_if.ctrl1_b7_o = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_bandai2003_unlock_host.sv
// ============================================================================
// Module   : tb_bandai2003_unlock_host
// Purpose  : Scoreboard bench for the unlock host with a behavioural cart.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bandai2003_unlock_host;

  typedef struct packed {
    logic [31:0] edge_n;
    logic        done;
    logic        fail;
    logic [15:0] rx;
    logic        ctrl;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  bandai2003_unlock_host_if host_if ();

  bandai2003_unlock_host #(
    .SYNC_STAGES (2),
    .TIMEOUT     (32),
    .EXPECT      (16'h28A0)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .host_if (host_if)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   e0           = 0;
  exp_t sb_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Cart model: answers one unlock per reset with start, payload, trailer.
  logic        m_present = 1'b1;
  logic [15:0] m_payload = 16'h28A0;
  logic        m_trailer = 1'b0;
  logic        m_so, m_prev_ack, m_locked;
  logic [16:0] m_sh;
  int          m_left;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_so <= 1'b1; m_prev_ack <= 1'b0; m_locked <= 1'b0; m_sh <= '1; m_left <= 0;
    end else begin
      m_prev_ack <= host_if.addr_oe_o && (host_if.addr_o == 8'h5A);
      if (m_left > 0) begin
        m_so   <= m_sh[0];
        m_sh   <= {1'b1, m_sh[16:1]};
        m_left <= m_left - 1;
      end else if (m_prev_ack && host_if.addr_oe_o && (host_if.addr_o == 8'hA5) &&
                   m_present && !m_locked) begin
        m_so     <= 1'b0;
        m_sh     <= {m_trailer, m_payload};
        m_left   <= 17;
        m_locked <= 1'b1;
      end else begin
        m_so <= 1'b1;
      end
    end
  end

  assign host_if.si_i = m_so;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic term_prev = 1'b0;
  always @(negedge clk_i) begin
    logic term;
    exp_t e;
    term = host_if.done_o | host_if.fail_o;
    if (!rst_i && term && !term_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("end_edge", 32'(cyc), e.edge_n);
        check("done", 32'(host_if.done_o), 32'(e.done));
        check("fail", 32'(host_if.fail_o), 32'(e.fail));
        check("rx_word", 32'(host_if.rx_word_o), 32'(e.rx));
        check("ctrl1_b7", 32'(host_if.ctrl1_b7_o), 32'(e.ctrl));
      end
    end
    term_prev = rst_i ? 1'b0 : term;
  end

  task automatic check_reset_vals();
    check("rst_addr", 32'(host_if.addr_o), 32'hFF);
    check("rst_oe", 32'(host_if.addr_oe_o), 32'd0);
    check("rst_busy", 32'(host_if.busy_o), 32'd0);
    check("rst_done", 32'(host_if.done_o), 32'd0);
    check("rst_fail", 32'(host_if.fail_o), 32'd0);
    check("rst_rx", 32'(host_if.rx_word_o), 32'd0);
    check("rst_ctrl", 32'(host_if.ctrl1_b7_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Pulses START, optionally queues the expected outcome, checks the bus phase.
  task automatic kick(input bit push, input int off, input logic d, input logic f,
                      input logic [15:0] rx, input logic c);
    exp_t e;
    @(negedge clk_i);
    host_if.start_i = 1'b1;
    e0 = cyc + 1;
    if (push) begin
      e.edge_n = 32'(e0 + off); e.done = d; e.fail = f; e.rx = rx; e.ctrl = c;
      sb_q.push_back(e);
    end
    @(negedge clk_i);
    host_if.start_i = 1'b0;
    check("addr_ack", 32'(host_if.addr_o), 32'h5A);
    check("oe_ack", 32'(host_if.addr_oe_o), 32'd1);
    @(negedge clk_i);
    check("addr_nak", 32'(host_if.addr_o), 32'hA5);
    check("oe_nak", 32'(host_if.addr_oe_o), 32'd1);
    @(negedge clk_i);
    check("addr_hunt", 32'(host_if.addr_o), 32'hFF);
    check("oe_hunt", 32'(host_if.addr_oe_o), 32'd0);
    check("busy_hunt", 32'(host_if.busy_o), 32'd1);
  endtask

  task automatic wait_sb(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("sb_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk_i);
  endtask

  initial begin
    host_if.start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_vals();
    rst_i = 1'b0;

    // Good unlock, then a re-run against the now-locked cart.
    kick(1'b1, 22, 1'b1, 1'b0, 16'h28A0, 1'b1);
    wait_sb(60);
    kick(1'b1, 34, 1'b0, 1'b1, 16'h28A0, 1'b1);
    wait_sb(60);

    // No cart: line stays high until timeout.
    do_reset();
    m_present = 1'b0;
    kick(1'b1, 34, 1'b0, 1'b1, 16'h0000, 1'b0);
    wait_sb(60);
    m_present = 1'b1;

    // Wrong payload.
    do_reset();
    m_payload = 16'h28A1;
    kick(1'b1, 22, 1'b0, 1'b1, 16'h28A1, 1'b0);
    wait_sb(60);
    m_payload = 16'h28A0;

    // Right payload, bad trailer.
    do_reset();
    m_trailer = 1'b1;
    kick(1'b1, 22, 1'b0, 1'b1, 16'h28A0, 1'b0);
    wait_sb(60);
    m_trailer = 1'b0;

    // Reset while receiving data, then a clean run.
    do_reset();
    kick(1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
    while (cyc < e0 + 9) @(negedge clk_i);
    check("busy_data", 32'(host_if.busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    kick(1'b1, 22, 1'b1, 1'b0, 16'h28A0, 1'b1);
    wait_sb(60);

    // START while busy must not restart the sequence.
    do_reset();
    kick(1'b1, 22, 1'b1, 1'b0, 16'h28A0, 1'b1);
    host_if.start_i = 1'b1;
    @(negedge clk_i);
    host_if.start_i = 1'b0;
    wait_sb(60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
